// File: rtl/conv2_stream.sv
// Streaming 2D valid-mode convolution over a raster pixel stream.
// Line buffers plus a KxK window feed a registered, saturating MAC.
module conv2_stream #(
    parameter int IMG_W     = 100,
    parameter int IMG_H     = 100,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    parameter int STRIDE    = 1,
    parameter int SHIFT     = 0
) (
    input  logic                                 clock,
    input  logic                                 nreset,
    input  logic                                 start,
    input  logic                                 ker_we,
    input  logic [$clog2(SIZEKer*SIZEKer)-1:0]   ker_addr,
    input  logic signed [WIDTH_BIT-1:0]          ker_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [WIDTH_BIT-1:0]          in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [WIDTH_BIT-1:0]          out_data,
    output logic                                 done,
    output logic                                 busy
);

    localparam int K     = SIZEKer;
    localparam int W     = WIDTH_BIT;
    localparam int KK    = K * K;
    localparam int ACC_W = 2 * W + $clog2(KK);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] cph_q, cph_d;
    logic [PW-1:0] rph_q, rph_d;

    logic          ovalid_q, ovalid_d;
    logic signed [W-1:0] odata_q, odata_d;
    logic          done_q, done_d;

    logic signed [W-1:0] ker_q [KK];
    logic signed [W-1:0] lb_q  [K-1][IMG_W];
    logic signed [W-1:0] win_q [K][K];
    logic signed [W-1:0] colv  [K];
    logic signed [W-1:0] nwin  [K][K];

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [W-1:0]     sat;

    logic in_fire;
    logic out_fire;
    logic col_last;
    logic row_last;
    logic win_done;

    assign in_ready  = (state_q == S_RUN) && (!ovalid_q || out_ready);
    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
    assign done      = done_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = ovalid_q && out_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign win_done = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1)) &&
                      (cph_q == '0) && (rph_q == '0);

    // Column entering the window and the window as it will look after intake
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            colv[i] = lb_q[i][col_q];
        end
        colv[K-1] = in_data;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                nwin[i][j] = win_q[i][j+1];
            end
            nwin[i][K-1] = colv[i];
        end
    end

    // Full-precision MAC, floor shift, saturate
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod = nwin[i][j] * ker_q[i*K+j];
                acc  = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
            end
        end
        acc_sh = acc >>> SHIFT;
        if (acc_sh > MAXV) begin
            sat = MAXV[W-1:0];
        end else if (acc_sh < MINV) begin
            sat = MINV[W-1:0];
        end else begin
            sat = acc_sh[W-1:0];
        end
    end

    // Line buffers and window shift registers (contents need no reset)
    always_ff @(posedge clock) begin
        if (in_fire) begin
            for (int i = 0; i < K - 2; i++) begin
                lb_q[i][col_q] <= lb_q[i+1][col_q];
            end
            lb_q[K-2][col_q] <= in_data;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= nwin[i][j];
                end
            end
        end
    end

    // Kernel coefficient store, writable only while idle
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < KK; i++) begin
                ker_q[i] <= '0;
            end
        end else if (state_q == S_IDLE && ker_we &&
                     32'(ker_addr) < KK) begin
            ker_q[ker_addr] <= ker_data;
        end
    end

    // Control state, counters and output register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            cph_q    <= '0;
            rph_q    <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cph_q    <= cph_d;
            rph_q    <= rph_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            done_q   <= done_d;
        end
    end

    // Next-state: frame sequencing, raster/phase counters, output load
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cph_d    = cph_q;
        rph_d    = rph_q;
        ovalid_d = out_fire ? 1'b0 : ovalid_q;
        odata_d  = odata_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    cph_d   = '0;
                    rph_d   = '0;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    if (win_done) begin
                        ovalid_d = 1'b1;
                        odata_d  = sat;
                    end
                    if (col_last) begin
                        col_d = '0;
                        cph_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            rph_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                            if (row_q >= RW'(K - 1)) begin
                                rph_d = (rph_q == PW'(STRIDE - 1)) ?
                                        '0 : rph_q + 1'b1;
                            end
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                        if (col_q >= CW'(K - 1)) begin
                            cph_d = (cph_q == PW'(STRIDE - 1)) ?
                                    '0 : cph_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!ovalid_q || out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv2_stream.sv
// Directed bench for conv2_stream: three parameterisations, model-checked.
// Covers identity, ones, saturation, stride, shift, stalls, reset, gating.
module tb_conv2_stream;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic [2:0]         start, ker_we, in_valid, out_ready;
    logic [3:0]         ker_addr [3];
    logic signed [15:0] ker_data [3];
    logic signed [15:0] in_data  [3];
    wire  [2:0]         in_ready, out_valid, done, busy;
    wire  signed [15:0] out_data [3];

    int dim_w [3] = '{5, 5, 7};
    int dim_h [3] = '{5, 5, 6};
    int dim_s [3] = '{1, 2, 1};
    int dim_f [3] = '{0, 0, 4};

    int img [0:5][0:6];
    int ker [9];
    int kmod [3][9];

    int nerr = 0;
    int nchk = 0;

    conv2_stream #(.IMG_W(5), .IMG_H(5), .SIZEKer(3), .WIDTH_BIT(16),
                   .STRIDE(1), .SHIFT(0)) u0 (
        .clock(clk), .nreset(nreset), .start(start[0]),
        .ker_we(ker_we[0]), .ker_addr(ker_addr[0]),
        .ker_data(ker_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .done(done[0]), .busy(busy[0]));

    conv2_stream #(.IMG_W(5), .IMG_H(5), .SIZEKer(3), .WIDTH_BIT(16),
                   .STRIDE(2), .SHIFT(0)) u1 (
        .clock(clk), .nreset(nreset), .start(start[1]),
        .ker_we(ker_we[1]), .ker_addr(ker_addr[1]),
        .ker_data(ker_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .done(done[1]), .busy(busy[1]));

    conv2_stream #(.IMG_W(7), .IMG_H(6), .SIZEKer(3), .WIDTH_BIT(16),
                   .STRIDE(1), .SHIFT(4)) u2 (
        .clock(clk), .nreset(nreset), .start(start[2]),
        .ker_we(ker_we[2]), .ker_addr(ker_addr[2]),
        .ker_data(ker_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .done(done[2]), .busy(busy[2]));

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                img[r][c] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                img[r][c] = 10 * r + c;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                img[r][c] = int'($urandom_range(4000)) - 2000;
    endtask

    task automatic load_ker(input int u);
        for (int a = 0; a < 9; a++) begin
            @(negedge clk);
            ker_we[u]   = 1'b1;
            ker_addr[u] = 4'(a);
            ker_data[u] = 16'(ker[a]);
            kmod[u][a]  = ker[a];
        end
        @(negedge clk);
        ker_we[u] = 1'b0;
    endtask

    task automatic run_frame(input int u, input int vp, input int rp,
                             input bit stall, input bit poke);
        int     exp_q[$];
        int     w, h, s, f, p, ocnt, dcnt, post, cyc, hold;
        bit     stalled;
        longint acc;
        w = dim_w[u];
        h = dim_h[u];
        s = dim_s[u];
        f = dim_f[u];
        for (int r = 2; r < h; r += s) begin
            for (int c = 2; c < w; c += s) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += longint'(img[r-2+i][c-2+j]) *
                               longint'(kmod[u][3*i+j]);
                acc = acc >>> f;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                exp_q.push_back(int'(acc));
            end
        end
        p = 0; ocnt = 0; dcnt = 0; post = 0; cyc = 0;
        hold = 0; stalled = 1'b0;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        while (post < 4 && cyc < 3000) begin
            if (poke && cyc == 3) begin
                ker_we[u]   = 1'b1;
                ker_addr[u] = 4'd4;
                ker_data[u] = 16'sd77;
                start[u]    = 1'b1;
            end else begin
                ker_we[u] = 1'b0;
                start[u]  = 1'b0;
            end
            in_valid[u] = (p < w * h) && ($urandom_range(99) < vp);
            in_data[u]  = (p < w * h) ? 16'(img[p / w][p % w]) : 16'sd0;
            if (stall && !stalled && out_valid[u]) begin
                stalled = 1'b1;
                hold    = 10;
            end
            out_ready[u] = (hold > 0) ? 1'b0 : ($urandom_range(99) < rp);
            #1;
            if (hold > 0) begin
                chk("hold_in_ready", int'(in_ready[u]), 0);
                chk("hold_data", int'(out_data[u]), exp_q[0]);
                hold--;
            end
            if (in_valid[u] && in_ready[u]) p++;
            if (out_valid[u] && out_ready[u]) begin
                if (ocnt < exp_q.size())
                    chk($sformatf("u%0d_out%0d", u, ocnt),
                        int'(out_data[u]), exp_q[ocnt]);
                ocnt++;
            end
            if (done[u]) dcnt++;
            if (dcnt > 0) post++;
            cyc++;
            @(negedge clk);
        end
        in_valid[u]  = 1'b0;
        ker_we[u]    = 1'b0;
        start[u]     = 1'b0;
        out_ready[u] = 1'b1;
        chk($sformatf("u%0d_timeout", u), int'(cyc < 3000), 1);
        chk($sformatf("u%0d_nout", u), ocnt, exp_q.size());
        chk($sformatf("u%0d_ndone", u), dcnt, 1);
        chk($sformatf("u%0d_busy_end", u), int'(busy[u]), 0);
    endtask

    task automatic abort_frame();
        int dcnt;
        dcnt = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0]     = 1'b0;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 16'(img[k / 5][k % 5]);
            #1;
            if (done[0]) dcnt++;
            @(negedge clk);
        end
        chk("abort_busy_mid", int'(busy[0]), 1);
        in_valid[0] = 1'b0;
        nreset      = 1'b0;
        #1;
        chk("abort_busy_rst", int'(busy[0]), 0);
        chk("abort_oval_rst", int'(out_valid[0]), 0);
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (done[0]) dcnt++;
            @(negedge clk);
        end
        chk("abort_no_done", dcnt, 0);
        for (int u = 0; u < 3; u++)
            for (int a = 0; a < 9; a++)
                kmod[u][a] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset    = 1'b0;
        start     = '0;
        ker_we    = '0;
        in_valid  = '0;
        out_ready = '1;
        for (int u = 0; u < 3; u++) begin
            ker_addr[u] = '0;
            ker_data[u] = '0;
            in_data[u]  = '0;
            for (int a = 0; a < 9; a++) kmod[u][a] = 0;
        end
        #12;
        chk("rst_in_ready", int'(in_ready[0]), 0);
        chk("rst_out_valid", int'(out_valid[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_out_data", int'(out_data[0]), 0);
        @(negedge clk);
        nreset = 1'b1;

        // identity kernel on ramp image
        ker = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_ker(0);
        fill_ramp();
        run_frame(0, 100, 100, 1'b0, 1'b0);

        // stall 10 cycles on first output, same stream afterwards
        run_frame(0, 100, 100, 1'b1, 1'b0);

        // ker_we and start during RUN are ignored
        run_frame(0, 100, 100, 1'b0, 1'b1);

        // all-ones kernel, all-ones image, stride 1 and 2
        ker = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_ker(0);
        load_ker(1);
        fill_const(1);
        run_frame(0, 100, 100, 1'b0, 1'b0);
        run_frame(1, 100, 100, 1'b0, 1'b0);

        // saturation at both rails
        fill_const(32767);
        run_frame(0, 100, 100, 1'b0, 1'b0);
        fill_const(-32768);
        run_frame(0, 100, 100, 1'b0, 1'b0);

        // shift by 4 on the 7x6 instance
        load_ker(2);
        fill_const(16);
        run_frame(2, 100, 100, 1'b0, 1'b0);

        // random gaps on both sides, random kernel and image
        for (int a = 0; a < 9; a++)
            ker[a] = int'($urandom_range(400)) - 200;
        load_ker(2);
        fill_rand();
        run_frame(2, 60, 55, 1'b0, 1'b0);
        fill_rand();
        run_frame(2, 45, 70, 1'b0, 1'b0);

        // mid-frame reset, then new kernel and a fresh frame
        fill_ramp();
        abort_frame();
        ker = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        load_ker(0);
        run_frame(0, 80, 80, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/conv2_stream.md
Name: conv2_stream

Overview:
Streaming successor to the frame-parallel conv2 block. It applies a 2D valid-mode convolution to a raster-order pixel stream of IMG_W x IMG_H signed samples. It uses a runtime-loadable SIZEKer x SIZEKer kernel, a configurable stride, an arithmetic output shift and saturation. It buffers SIZEKer-1 image lines internally and emits one output per completed window over a valid/ready handshake, with a done pulse at end of frame.

Parameters:
IMG_W, 100, image width in pixels (must be >= SIZEKer)
IMG_H, 100, image height in lines (must be >= SIZEKer)
SIZEKer, 3, kernel edge length (>= 2)
WIDTH_BIT, 16, signed width of pixels, kernel coefficients and outputs
STRIDE, 1, window step in both dimensions (>= 1)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..WIDTH_BIT)

Ports:
clock  in  1  single clock; all state updates on its rising edge
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
ker_we  in  1  kernel coefficient write strobe; honoured only in IDLE
ker_addr  in  clog2(SIZEKer*SIZEKer)  coefficient index, row-major (row*SIZEKer+col)
ker_data  in  WIDTH_BIT  signed coefficient
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  WIDTH_BIT  signed pixel, raster order
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  WIDTH_BIT  signed saturated result
done  out  1  one-cycle pulse after the last output of a frame is accepted
busy  out  1  high in RUN and DRAIN

Behaviour:
- Reset (asynchronous, nreset=0): state=IDLE; in_ready, out_valid, done and busy = 0; out_data = 0; row, column and stride counters = 0; kernel coefficients = 0; line-buffer contents are don't-care.
- States:
  - IDLE: on start go to RUN. A ker_we that arrives together with start is still applied in that cycle.
  - RUN: in_ready = !out_valid || out_ready. After the pixel at (IMG_H-1, IMG_W-1) is accepted, go to DRAIN.
  - DRAIN: in_ready = 0. When out_valid=0, or out_valid && out_ready, assert done for one cycle and go to IDLE.
- A start pulse outside IDLE is ignored. A ker_we outside IDLE is ignored, and the kernel is unchanged.
- Pixel intake: each accepted pixel is written into the line buffers and the SIZEKer x SIZEKer window shift registers. Column and row counters advance with the pixel, and the column wraps to 0 at IMG_W-1.
- Window at pixel (r,c) is complete when both hold:
  - r >= SIZEKer-1 and c >= SIZEKer-1;
  - (r-SIZEKer+1) mod STRIDE == 0 and (c-SIZEKer+1) mod STRIDE == 0. Implement both with phase counters, not dividers.
- Outputs per frame: ((IMG_H-SIZEKer)/STRIDE+1) x ((IMG_W-SIZEKer)/STRIDE+1), in raster order.
- Arithmetic:
  - acc = sum of window[i][j]*kernel[i][j] at full precision, ACC_W = 2*WIDTH_BIT + clog2(SIZEKer*SIZEKer) bits, signed.
  - acc is arithmetic-shifted right by SHIFT, truncating toward minus infinity.
  - The result then saturates to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1].
- Latency: out_valid rises on the clock edge that accepts the completing pixel, so the output is registered one cycle after acceptance.
- Output register:
  - Single entry. out_data is held stable while out_valid && !out_ready.
  - Accept and reload in the same cycle is allowed, giving full throughput of one pixel per cycle.
- Backpressure: while out_valid && !out_ready, in_ready=0 and no pixel is lost or duplicated.
- in_valid=0 in RUN: counters and window hold, with no bubble artefacts.
- Reset mid-frame: the frame is abandoned, no done is asserted, and the next start processes a fresh frame correctly.
- The kernel persists across frames until rewritten.

Test Plan:
1. Identity kernel (centre=1, others 0), IMG 5x5, K=3, STRIDE=1, SHIFT=0, pixels p(r,c)=10r+c -> 9 outputs equal 11,12,13,21,22,23,31,32,33 in order, then a single done pulse.
2. All-ones kernel with all-ones 5x5 image -> 9 outputs of 9. Repeat with STRIDE=2 -> exactly 4 outputs of 9, at windows (0,0),(0,2),(2,0),(2,2).
3. Saturation with all-ones kernel and SHIFT=0: image all 0x7FFF -> every output 0x7FFF; image all 0x8000 -> every output 0x8000. Repeat with SHIFT=4 and pixels all 16 -> outputs 9.
4. Backpressure: hold out_ready=0 for 10 cycles after the first out_valid -> in_ready=0, out_data stable. After release, the output sequence is identical to scenario 1.
5. Randomised in_valid and out_ready gaps on a 7x6 image -> output stream bit-matches a software model; done occurs exactly once.
6. Assert nreset for 1 cycle mid-frame, then write a new kernel, then start again -> outputs match the new kernel. A ker_we issued during RUN does not change the kernel, and a start pulse during RUN is ignored.
